// File: rtl/jtag_scan_seq.sv
// ---------------------------------------------------------------------------
// jtag_scan_seq
//   JTAG master scan sequencer. It accepts one IR or DR scan request at a
//   time and walks the target TAP from Run-Test/Idle through the Shift
//   state and back. It captures TDO into a right-justified response word
//   and holds that response until the consumer takes it.
//
//   Every TAP step lasts one TCK period of 2*ClkDiv clk_i cycles. TCK is low
//   for the first half of the period and high for the second half. TMS and
//   TDI change only when a step starts. TDO is sampled on the clk_i edge that
//   drives TCK high.
//
// Parameters
//   ClkDiv         clk_i cycles per TCK half-period (1..255)
//   RunTestCycles  extra Run-Test/Idle steps after each scan (runtest build)
//
// Optional feature
//   JTAG_SCAN_SEQ_RUNTEST_EN  when defined, a RUNTEST state after POST issues
//                             RunTestCycles TMS=0 steps before the response.
//
// Ports
//   clk_i, rst_i              clock, async active-high reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE)
//   req_ir_i                  1 = IR scan, 0 = DR scan
//   req_len_i                 scan length minus 1 (1..64 bits)
//   req_data_i                TDI bits, LSB first
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_data_o                captured TDO bits, bit i = i-th shifted bit
//   tck_o, tms_o, tdi_o       JTAG pins driven by the master
//   tdo_i                     JTAG TDO, already synchronous to clk_i
// ---------------------------------------------------------------------------
module jtag_scan_seq #(
  parameter int ClkDiv        = 2,
  parameter int RunTestCycles = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_ir_i,
  input  logic [5:0]  req_len_i,
  input  logic [63:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_data_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  // The step counter must cover shift bits 0..63. In the runtest build it
  // must also cover RunTestCycles-1.
  localparam int CntW = (RunTestCycles > 64) ? $clog2(RunTestCycles) : 6;

  // The phase counter spans one TCK period, 0 .. 2*ClkDiv-1, at most 509.
  localparam logic [8:0] PhRise = 9'(ClkDiv - 1);      // last low cycle
  localparam logic [8:0] PhEnd  = 9'(2 * ClkDiv - 1);  // last high cycle

`ifdef JTAG_SCAN_SEQ_RUNTEST_EN
  localparam logic [CntW-1:0] RtLast = CntW'(RunTestCycles - 1);
  typedef enum logic [2:0] {
    TLR_SEQ, IDLE, PRE, SHIFT, POST, RUNTEST, RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    TLR_SEQ, IDLE, PRE, SHIFT, POST, RESP
  } state_t;
`endif

  state_t          state;
  logic [8:0]      ph;
  logic [CntW-1:0] cnt;
  logic            scan_ir;
  logic [5:0]      scan_len;
  logic [63:0]     scan_data;

  // These are helpers for the step-end decisions.
  logic [5:0]      bit_idx;
  logic [5:0]      bit_nxt;
  logic [CntW-1:0] pre_last;

  always_comb begin
    bit_idx  = cnt[5:0];
    bit_nxt  = cnt[5:0] + 6'd1;
    pre_last = scan_ir ? CntW'(3) : CntW'(2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= TLR_SEQ;
      ph          <= '0;
      cnt         <= '0;
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;  // first TLR step drives TMS=1
      tdi_o       <= 1'b0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      scan_ir     <= 1'b0;
      scan_len    <= '0;
      scan_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            scan_ir     <= req_ir_i;
            scan_len    <= req_len_i;
            scan_data   <= req_data_i;
            rsp_data_o  <= '0;
            req_ready_o <= 1'b0;
            state       <= PRE;
            cnt         <= '0;
            ph          <= '0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;  // Select-DR-Scan
            tdi_o       <= 1'b0;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        // These are the stepping states: TLR_SEQ, PRE, SHIFT, POST and RUNTEST.
        default: begin
          if (ph == PhRise) begin
            // This edge raises TCK. It is also the TDO sample point.
            tck_o <= 1'b1;
            ph    <= ph + 9'd1;
            if (state == SHIFT)
              rsp_data_o[bit_idx] <= tdo_i;
          end else if (ph == PhEnd) begin
            // The step ends here. Set up TMS/TDI for the next step with TCK low.
            tck_o <= 1'b0;
            ph    <= '0;
            case (state)
              TLR_SEQ: begin
                if (cnt == CntW'(5)) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  tms_o       <= 1'b0;
                  req_ready_o <= 1'b1;
                end else begin
                  cnt   <= cnt + CntW'(1);
                  tms_o <= (cnt < CntW'(4));  // steps 0..4 TMS=1, step 5 TMS=0
                end
              end

              PRE: begin
                if (cnt == pre_last) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  tms_o <= (scan_len == 6'd0);
                  tdi_o <= scan_data[0];
                end else begin
                  cnt   <= cnt + CntW'(1);
                  // IR path: 1,1,0,0. DR path: 1,0,0.
                  tms_o <= scan_ir && (cnt == '0);
                end
              end

              SHIFT: begin
                if (bit_idx == scan_len) begin
                  state <= POST;   // Exit1 was reached on the last bit
                  cnt   <= '0;
                  tms_o <= 1'b1;   // Update
                  tdi_o <= 1'b0;
                end else begin
                  cnt   <= cnt + CntW'(1);
                  tdi_o <= scan_data[bit_nxt];
                  tms_o <= (bit_nxt == scan_len);
                end
              end

              POST: begin
                if (cnt == '0) begin
                  cnt   <= CntW'(1);
                  tms_o <= 1'b0;   // back to Run-Test/Idle
                end else begin
                  cnt   <= '0;
                  tms_o <= 1'b0;
`ifdef JTAG_SCAN_SEQ_RUNTEST_EN
                  if (RunTestCycles > 0) begin
                    state <= RUNTEST;
                  end else begin
                    state       <= RESP;
                    rsp_valid_o <= 1'b1;
                  end
`else
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
`endif
                end
              end

`ifdef JTAG_SCAN_SEQ_RUNTEST_EN
              RUNTEST: begin
                if (cnt == RtLast) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  cnt         <= '0;
                end else begin
                  cnt <= cnt + CntW'(1);
                end
                tms_o <= 1'b0;
              end
`endif

              default: begin
                state <= TLR_SEQ;
                cnt   <= '0;
                tms_o <= 1'b1;
              end
            endcase
          end else begin
            ph <= ph + 9'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/jtag_scan_seq.md
JTAG_SCAN_SEQ -- requirements
Module: jtag_scan_seq

Interface
REQ-001 SHALL have parameter ClkDiv, default 2: clk_i cycles per TCK half-period; legal range 1..255.
REQ-002 SHALL have parameter RunTestCycles, default 1: extra Run-Test/Idle TCK periods after each scan (used only with the Configuration macro).
REQ-003 clk_i  in  1  system clock; the only clock.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 req_valid_i  in  1  scan request valid.
REQ-006 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-007 req_ir_i  in  1  1 = IR scan, 0 = DR scan.
REQ-008 req_len_i  in  6  scan length minus 1 (1..64 bits).
REQ-009 req_data_i  in  64  TDI data, LSB shifted first.
REQ-010 rsp_valid_o  out  1  response valid.
REQ-011 rsp_ready_i  in  1  response consumed when valid and ready are both high.
REQ-012 rsp_data_o  out  64  captured TDO bits, right-justified, unused upper bits 0.
REQ-013 tck_o / tms_o / tdi_o  out  1 each  JTAG master pins.
REQ-014 tdo_i  in  1  JTAG TDO, already synchronous to clk_i.

Function
REQ-015 One TAP step SHALL be one TCK period of 2*ClkDiv clk_i cycles: tck_o low for the first ClkDiv cycles, high for the last ClkDiv cycles.
REQ-016 tms_o and tdi_o SHALL change only at step start, i.e. the cycle tck_o falls or stays low.
REQ-017 tdo_i SHALL be sampled on the clk_i edge that drives tck_o high, during shift steps only.
REQ-018 States SHALL be: TLR_SEQ, IDLE, PRE, SHIFT, POST, (RUNTEST), RESP.
REQ-019 TLR_SEQ SHALL issue 5 steps with TMS=1, then 1 step with TMS=0, leaving the target TAP in Run-Test/Idle.
REQ-020 req_ready_o SHALL be high only in IDLE; on acceptance the length, type and data SHALL be latched.
REQ-021 PRE for a DR scan SHALL issue TMS 1,0,0; for an IR scan TMS 1,1,0,0.
REQ-022 SHIFT SHALL issue len+1 steps: TDI = data bit i; TMS=0 except TMS=1 on the last bit.
REQ-023 POST SHALL issue TMS 1,0 (Update, then Run-Test/Idle).
REQ-024 Captured bit i (i-th shift step) SHALL land in rsp_data_o[i].
REQ-025 rsp_valid_o SHALL rise the cycle after the final POST/RUNTEST step ends and hold, with stable data, until rsp_ready_i.
REQ-026 On the handshake, the block SHALL return to IDLE; a new request is accepted no earlier than the next cycle.
REQ-027 A new request SHALL NOT be accepted while rsp_valid_o is high.
REQ-028 In IDLE, tck_o SHALL be 0, tms_o 0, tdi_o 0; no TCK toggles.
REQ-029 Step and bit counters SHALL never wrap: a 64-bit scan (req_len_i=63) shifts exactly 64 bits.

Reset
REQ-030 While rst_i is high: tck_o=0, tms_o=1, tdi_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, state=TLR_SEQ.
REQ-031 After rst_i deasserts, TLR_SEQ SHALL run before IDLE is entered.
REQ-032 rst_i mid-scan SHALL abort the scan immediately, drop any pending response and restart TLR_SEQ.

Configuration
REQ-033 Macro JTAG_SCAN_SEQ_RUNTEST_EN: when defined, a RUNTEST state after POST SHALL issue RunTestCycles extra steps with TMS=0 before RESP.
REQ-034 When the macro is undefined, the RUNTEST state and its counter SHALL be absent and RESP SHALL follow POST directly.

Verification (ClkDiv=2, macro undefined unless stated)
REQ-035 Release rst_i -> 6 steps (TMS 1,1,1,1,1,0), 24 cycles, then req_ready_o=1.
REQ-036 DR scan, len=7, data=0xA5, tdo_i loopback of tdi_o -> 13 steps (52 cycles), rsp_data_o=0xA5.
REQ-037 IR scan, len=4, data=0x11, TAP model captures 0b00101 -> TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data_o=0x05.
REQ-038 64-bit DR scan of 0x8000_0000_0000_0001 with loopback -> 69 steps, rsp_data_o identical; rsp_ready_i held low 10 cycles -> data stable and req_ready_o=0 throughout.
REQ-039 Assert rst_i during SHIFT bit 20 -> outputs at reset values within the same cycle, no rsp_valid_o, TLR_SEQ restarts.
REQ-040 Macro defined, RunTestCycles=3, DR len=7 -> 16 steps (64 cycles) before rsp_valid_o.
